// File: rtl/load_align_unit.sv
// Memory-stage load unit: byte/half/word loads at any byte address, split into two
// memory beats when the access straddles a word; result aligned, extended, registered.
// Latency: accept to ReadValid is 2 cycles (aligned) or 3 cycles (split) plus memory
// wait cycles.
// Backpressure: StallM holds the pipeline from accept until the last beat is acked;
// memory stalls by withholding MemAck.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word loads
// on MisalignExc instead of servicing them.
module load_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              LoadReqM,
    input  logic [ADDR_W-1:0] AddrM,
    input  logic [1:0]        MemReadM,
    input  logic              SignedM,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              StallM
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              MisalignExc
`endif
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int BYTES = DATA_W / 8;
    localparam logic [OFF_W+1:0] BYTES_W = (OFF_W + 2)'(BYTES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t              state_q;
    logic [OFF_W-1:0]    off_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic                split_q;
    logic [DATA_W-1:0]   lo_buf_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_rd_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_vld_q;
`ifdef MISALIGN_TRAP_EN
    logic                exc_q;
    logic                req_misalign;
`endif

    logic                req_vld;
    logic [OFF_W-1:0]    req_off;
    logic [OFF_W+1:0]    req_bytes;
    logic                req_split;
    logic [ADDR_W-1:0]   req_word_addr;

    logic [DATA_W-1:0]   beat_lo;
    logic [DATA_W-1:0]   beat_hi;
    logic [2*DATA_W-1:0] pair;
    logic [DATA_W-1:0]   win;
    logic [DATA_W-1:0]   keep_mask;
    logic                sign_bit;
    logic [DATA_W-1:0]   rd_data_d;

    // Decode the incoming request: size in bytes, offset, straddle test.
    always_comb begin
        req_vld       = LoadReqM && (MemReadM != 2'd0);
        req_off       = AddrM[OFF_W-1:0];
        req_word_addr = {AddrM[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        case (MemReadM)
            2'd1:    req_bytes = (OFF_W + 2)'(1);
            2'd2:    req_bytes = (OFF_W + 2)'(2);
            default: req_bytes = (OFF_W + 2)'(4);
        endcase
        req_split = ({2'b00, req_off} + req_bytes) > BYTES_W;
`ifdef MISALIGN_TRAP_EN
        req_misalign = ((MemReadM == 2'd2) && req_off[0]) ||
                       ((MemReadM == 2'd3) && (req_off[1:0] != 2'b00));
`endif
    end

    // Align and extend the result from the beat being acked this cycle. The high
    // word is only ever the BEAT1 data, so it is taken straight from MemData and
    // never needs its own buffer; it is zero on the non-split path.
    always_comb begin
        beat_lo = lo_buf_q;
        beat_hi = '0;
        if (state_q == BEAT0) begin
            beat_lo = MemData;
        end else if (state_q == BEAT1) begin
            beat_hi = MemData;
        end
        pair = {beat_hi, beat_lo};
        win  = DATA_W'(pair >> {off_q, 3'b000});
        case (size_q)
            2'd1: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = win[7];
            end
            2'd2: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = win[15];
            end
            default: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = win[31];
            end
        endcase
        rd_data_d = (win & keep_mask) | ((signed_q && sign_bit) ? ~keep_mask : '0);
    end

    // Load FSM with all memory and writeback outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            off_q      <= '0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            split_q    <= 1'b0;
            lo_buf_q   <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            exc_q      <= 1'b0;
`endif
        end else begin
            rd_vld_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            exc_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_vld) begin
                        off_q    <= req_off;
                        size_q   <= MemReadM;
                        signed_q <= SignedM;
                        split_q  <= req_split;
`ifdef MISALIGN_TRAP_EN
                        if (req_misalign) begin
                            // No memory traffic; ReadData keeps its old value.
                            state_q  <= DONE;
                            rd_vld_q <= 1'b1;
                            exc_q    <= 1'b1;
                        end else begin
                            state_q    <= BEAT0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= req_word_addr;
                        end
`else
                        state_q    <= BEAT0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= req_word_addr;
`endif
                    end
                end
                BEAT0: begin
                    if (MemAck) begin
                        lo_buf_q <= MemData;
                        if (split_q) begin
                            state_q    <= BEAT1;
                            mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
                        end else begin
                            state_q   <= DONE;
                            mem_rd_q  <= 1'b0;
                            rd_data_q <= rd_data_d;
                            rd_vld_q  <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (MemAck) begin
                        state_q   <= DONE;
                        mem_rd_q  <= 1'b0;
                        rd_data_q <= rd_data_d;
                        rd_vld_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall while memory is outstanding, including the accept cycle itself.
    always_comb begin
        StallM = (state_q == BEAT0) || (state_q == BEAT1) ||
                 ((state_q == IDLE) && req_vld);
    end

    assign MemAddr   = mem_addr_q;
    assign MemRd     = mem_rd_q;
    assign ReadData  = rd_data_q;
    assign ReadValid = rd_vld_q;
`ifdef MISALIGN_TRAP_EN
    assign MisalignExc = exc_q;
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit (DATA_W=32): directed scenarios plus
// randomized loads checked against a byte-addressed memory model.
// Follows MISALIGN_TRAP_EN the same way as the design.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        LoadReqM;
    logic [31:0] AddrM;
    logic [1:0]  MemReadM;
    logic        SignedM;
    logic [31:0] MemAddr;
    logic        MemRd;
    logic        MemAck;
    logic [31:0] MemData;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        StallM;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignExc;
`endif

    load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .LoadReqM(LoadReqM), .AddrM(AddrM),
        .MemReadM(MemReadM), .SignedM(SignedM), .MemAddr(MemAddr), .MemRd(MemRd),
        .MemAck(MemAck), .MemData(MemData), .ReadData(ReadData),
        .ReadValid(ReadValid), .StallM(StallM)
`ifdef MISALIGN_TRAP_EN
        , .MisalignExc(MisalignExc)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    bit          mem_en = 1'b1;
    logic [31:0] beat_q[$];
    logic [31:0] seed;
    logic [31:0] ovr[logic [31:0]];
    logic [31:0] exp_last = 32'h0;

    // Memory contents: explicit overrides, otherwise a hash of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (ovr.exists(wa)) return ovr[wa];
        return (wa * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] ba);
        logic [31:0] w;
        w = mem_word({ba[31:2], 2'b00});
        return 8'(w >> (8 * ba[1:0]));
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    endfunction

    // Reference load: gather S consecutive bytes little-endian, then extend.
    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sg);
        int          n;
        logic [31:0] v;
        n = size_bytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | ({24'h0, mem_byte(a + 32'(i))} << (8 * i));
        if (sg && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return ((sz == 2'd2) && a[0]) || ((sz == 2'd3) && (a[1:0] != 2'b00));
    endfunction

    // Memory responder: acks each beat after wait_cfg idle cycles.
    always @(negedge clk) begin
        if (mem_en) begin
            if (MemRd && !reset) begin
                if (wait_cnt < wait_cfg) begin
                    MemAck  = 1'b0;
                    MemData = $urandom;
                    wait_cnt++;
                end else begin
                    MemAck  = 1'b1;
                    MemData = mem_word(MemAddr);
                    beat_q.push_back(MemAddr);
                    wait_cnt = 0;
                end
            end else begin
                MemAck   = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Issue one load and observe it; all judgement is left to the caller.
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                           input int wt, output logic [31:0] data, output int lat,
                           output int stalls, output logic exc, output int nbeats,
                           output logic [31:0] b0, output logic [31:0] b1,
                           output bit hold_ok, output bit single_ok, output bit timeout);
        bit          have_prev;
        bit          got;
        logic        prev_ack;
        logic [31:0] prev_addr;
        wait_cfg = wt;
        beat_q.delete();
        lat = 0; stalls = 0; exc = 1'b0; hold_ok = 1'b1; timeout = 1'b0;
        have_prev = 1'b0; got = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        data = 32'h0;
        @(negedge clk);
        LoadReqM = 1'b1; AddrM = a; MemReadM = sz; SignedM = sg;
        #1;
        single_ok = !ReadValid;
        if (StallM) stalls++;
        @(negedge clk);
        LoadReqM = 1'b0; MemReadM = 2'd0; AddrM = $urandom;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            lat++;
            if (ReadValid) begin
                got  = 1'b1;
                data = ReadData;
`ifdef MISALIGN_TRAP_EN
                exc = MisalignExc;
`endif
                if (StallM || MemRd) hold_ok = 1'b0;
            end else begin
                if (StallM) stalls++;
                if (!(MemRd && StallM)) hold_ok = 1'b0;
                if (have_prev && !prev_ack && (MemAddr !== prev_addr)) hold_ok = 1'b0;
`ifdef MISALIGN_TRAP_EN
                if (MisalignExc) hold_ok = 1'b0;
`endif
                have_prev = 1'b1; prev_ack = MemAck; prev_addr = MemAddr;
                @(negedge clk);
            end
        end
        timeout = !got;
        nbeats = beat_q.size();
        b0 = (nbeats > 0) ? beat_q[0] : 32'h0;
        b1 = (nbeats > 1) ? beat_q[1] : 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; LoadReqM = 1'b0; AddrM = 32'h0; MemReadM = 2'd0; SignedM = 1'b0;
        MemAck = 1'b0; MemData = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({MemRd, MemAddr, ReadData, ReadValid, StallM} !== 67'h0) begin
            n_err++;
            $display("FAIL reset_state: got rd=%b addr=%h data=%h vld=%b stall=%b, expected all zero",
                     MemRd, MemAddr, ReadData, ReadValid, StallM);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_last = 32'h0;
    endtask

    task automatic test_aligned_word();
        logic [31:0] d, b0, b1; int lat, st, nb; logic ex; bit h, s, to;
        ovr[32'h100] = 32'hDEAD_BEEF;
        do_load(32'h100, 2'd3, 1'b0, 0, d, lat, st, ex, nb, b0, b1, h, s, to);
        n_cmp++;
        if (to || d !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL word_data: got %h expected deadbeef (timeout=%0d)", d, to);
        end
        n_cmp++;
        if (lat != 2 || st != 2) begin
            n_err++; $display("FAIL word_latency: got lat=%0d stall=%0d expected 2/2", lat, st);
        end
        n_cmp++;
        if (nb != 1 || b0 !== 32'h100) begin
            n_err++; $display("FAIL word_beats: got n=%0d a0=%h expected 1 beat at 00000100", nb, b0);
        end
        exp_last = 32'hDEAD_BEEF;
    endtask

    task automatic test_byte_sign();
        logic [31:0] d, b0, b1; int lat, st, nb; logic ex; bit h, s, to;
        ovr[32'h100] = 32'h80FF_FFFF;
        do_load(32'h103, 2'd1, 1'b1, 0, d, lat, st, ex, nb, b0, b1, h, s, to);
        n_cmp++;
        if (to || d !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL byte_signed: got %h expected ffffff80", d);
        end
        do_load(32'h103, 2'd1, 1'b0, 0, d, lat, st, ex, nb, b0, b1, h, s, to);
        n_cmp++;
        if (to || d !== 32'h0000_0080 || lat != 2) begin
            n_err++; $display("FAIL byte_unsigned: got %h lat=%0d expected 00000080 lat=2", d, lat);
        end
        exp_last = 32'h0000_0080;
    endtask

    task automatic test_split_half();
        logic [31:0] d, b0, b1; int lat, st, nb; logic ex; bit h, s, to;
        ovr[32'h200] = 32'hAB00_0000;
        ovr[32'h204] = 32'h0000_00CD;
        do_load(32'h203, 2'd2, 1'b0, 0, d, lat, st, ex, nb, b0, b1, h, s, to);
        n_cmp++;
        if (to || d !== 32'h0000_CDAB) begin
            n_err++; $display("FAIL split_unsigned: got %h expected 0000cdab", d);
        end
        n_cmp++;
        if (nb != 2 || b0 !== 32'h200 || b1 !== 32'h204) begin
            n_err++; $display("FAIL split_beats: got n=%0d %h %h expected 00000200 00000204", nb, b0, b1);
        end
        n_cmp++;
        if (st != 3 || lat != 3) begin
            n_err++; $display("FAIL split_stall: got stall=%0d lat=%0d expected 3/3", st, lat);
        end
        do_load(32'h203, 2'd2, 1'b1, 0, d, lat, st, ex, nb, b0, b1, h, s, to);
        n_cmp++;
        if (to || d !== 32'hFFFF_CDAB) begin
            n_err++; $display("FAIL split_signed: got %h expected ffffcdab", d);
        end
        exp_last = 32'hFFFF_CDAB;
    endtask

    task automatic test_wait_states();
        logic [31:0] d, b0, b1; int lat, st, nb; logic ex; bit h, s, to;
        ovr[32'h100] = 32'hDEAD_BEEF;
        do_load(32'h100, 2'd3, 1'b0, 3, d, lat, st, ex, nb, b0, b1, h, s, to);
        n_cmp++;
        if (to || d !== 32'hDEAD_BEEF || lat != 5 || st != 5) begin
            n_err++; $display("FAIL wait_states: got %h lat=%0d stall=%0d expected deadbeef 5/5", d, lat, st);
        end
        n_cmp++;
        if (!h || nb != 1) begin
            n_err++; $display("FAIL wait_hold: got hold_ok=%0d beats=%0d expected 1/1", h, nb);
        end
        exp_last = 32'hDEAD_BEEF;
    endtask

    task automatic test_misalign();
        logic [31:0] d, b0, b1, e; int lat, st, nb; logic ex; bit h, s, to;
        ovr[32'h100] = 32'h1122_3344;
        ovr[32'h104] = 32'h5566_7788;
        do_load(32'h102, 2'd3, 1'b0, 0, d, lat, st, ex, nb, b0, b1, h, s, to);
`ifdef MISALIGN_TRAP_EN
        e = exp_last;
        n_cmp++;
        if (to || ex !== 1'b1 || lat != 1 || nb != 0 || d !== e) begin
            n_err++; $display("FAIL misalign_trap: got exc=%b lat=%0d beats=%0d data=%h expected 1/1/0/%h",
                              ex, lat, nb, d, e);
        end
`else
        e = exp_load(32'h102, 2'd3, 1'b0);
        n_cmp++;
        if (to || d !== e || nb != 2 || b0 !== 32'h100 || b1 !== 32'h104 || lat != 3) begin
            n_err++; $display("FAIL misalign_split: got %h beats=%0d %h %h lat=%0d expected %h 2 beats 100/104 lat=3",
                              d, nb, b0, b1, lat, e);
        end
`endif
        exp_last = e;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, b0, b1, e; int lat, st, nb; logic ex; bit h, s, to;
        for (int i = 0; i < 3; i++) begin
            e = exp_load(32'h300 + 32'(4 * i), 2'd3, 1'b0);
            do_load(32'h300 + 32'(4 * i), 2'd3, 1'b0, 0, d, lat, st, ex, nb, b0, b1, h, s, to);
            n_cmp++;
            if (to || d !== e || lat != 2 || st != 2 || !s) begin
                n_err++; $display("FAIL back_to_back[%0d]: got %h lat=%0d stall=%0d single=%0d expected %h 2/2/1",
                                  i, d, lat, st, s, e);
            end
            exp_last = e;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        mem_en = 1'b0;
        MemAck = 1'b0;
        @(negedge clk);
        LoadReqM = 1'b1; AddrM = 32'h203; MemReadM = 2'd2; SignedM = 1'b0;
        @(negedge clk);
        LoadReqM = 1'b0; MemReadM = 2'd0;
        #1;
        MemAck = 1'b1; MemData = 32'hAB00_0000;
        @(negedge clk);
        MemAck = 1'b0;
        #1;
        n_cmp++;
        if (MemRd !== 1'b1 || MemAddr !== 32'h204) begin
            n_err++; $display("FAIL mid_beat1: got rd=%b addr=%h expected 1 00000204", MemRd, MemAddr);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (MemRd !== 1'b0 || StallM !== 1'b0 || ReadValid !== 1'b0 || ReadData !== 32'h0) begin
            n_err++; $display("FAIL reset_mid: got rd=%b stall=%b vld=%b data=%h expected 0 0 0 0",
                              MemRd, StallM, ReadValid, ReadData);
        end
        @(negedge clk);
        reset = 1'b0;
        MemAck = 1'b1; MemData = 32'h0000_00CD;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (ReadValid !== 1'b0 || MemRd !== 1'b0) ok = 1'b0;
        end
        MemAck = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL late_ack: got a ReadValid or MemRd after reset, expected none");
        end
        mem_en = 1'b1;
        exp_last = 32'h0;
    endtask

    task automatic test_random();
        logic [31:0] a, d, b0, b1, e, eb0, eb1; int lat, st, nb, wt, enb, elat;
        logic [1:0] sz; logic sg, ex, eex; bit h, s, to;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: a = 32'h0000_0400 + 32'($urandom_range(0, 15));
            endcase
            sz = 2'($urandom_range(1, 3));
            sg = 1'($urandom_range(0, 1));
            wt = $urandom_range(0, 2);
            e   = exp_load(a, sz, sg);
            enb = (int'(a[1:0]) + size_bytes(sz) > 4) ? 2 : 1;
            eex = 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (is_misaligned(a, sz)) begin
                e = exp_last; enb = 0; eex = 1'b1;
            end
`endif
            elat = (enb == 0) ? 1 : (enb + 1 + wt * enb);
            eb0 = (enb > 0) ? {a[31:2], 2'b00} : 32'h0;
            eb1 = (enb > 1) ? ({a[31:2], 2'b00} + 32'd4) : 32'h0;
            do_load(a, sz, sg, wt, d, lat, st, ex, nb, b0, b1, h, s, to);
            n_cmp++;
            if (to || d !== e || ex !== eex) begin
                n_err++; $display("FAIL rand_data[%0d]: a=%h sz=%0d sg=%0d got %h exc=%b expected %h exc=%b",
                                  i, a, sz, sg, d, ex, e, eex);
            end
            n_cmp++;
            if (lat != elat || st != elat) begin
                n_err++; $display("FAIL rand_timing[%0d]: a=%h sz=%0d wt=%0d got lat=%0d stall=%0d expected %0d",
                                  i, a, sz, wt, lat, st, elat);
            end
            n_cmp++;
            if (nb != enb || b0 !== eb0 || b1 !== eb1) begin
                n_err++; $display("FAIL rand_beats[%0d]: a=%h got n=%0d %h %h expected n=%0d %h %h",
                                  i, a, nb, b0, b1, enb, eb0, eb1);
            end
            n_cmp++;
            if (!h || !s) begin
                n_err++; $display("FAIL rand_handshake[%0d]: got hold_ok=%0d single_pulse=%0d expected 1/1",
                                  i, h, s);
            end
            exp_last = e;
        end
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_aligned_word();
        test_byte_sign();
`ifndef MISALIGN_TRAP_EN
        test_split_half();
`endif
        test_wait_states();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        ovr.delete();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised memory-stage load unit that replaces the combinational load mask.
- Accepts byte, half and word loads at any byte address.
- Splits unaligned accesses that straddle a memory word into two memory beats.
- Byte-aligns, zero- or sign-extends and registers the result for writeback.
- Holds the pipeline with StallM while memory is outstanding.

Parameters:
DATA_W, 32, memory and register data width in bits; legal values 32 or 64.
ADDR_W, 32, byte address width.
OFF_W, log2(DATA_W/8), byte-offset bits within a memory word (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
LoadReqM  input  1  load request from the M stage.
AddrM  input  ADDR_W  byte address of the load.
MemReadM  input  2  access size: 0 none, 1 byte, 2 half, 3 word (32 bits).
SignedM  input  1  1 = sign-extend, 0 = zero-extend.
MemAddr  output  ADDR_W  word-aligned address to data memory.
MemRd  output  1  memory read strobe.
MemAck  input  1  memory has MemData valid for the current MemAddr.
MemData  input  DATA_W  memory read data, little-endian.
ReadData  output  DATA_W  aligned, extended load result.
ReadValid  output  1  one-cycle pulse: ReadData is valid.
StallM  output  1  pipeline hold request.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE.
  - MemRd=0, MemAddr=0, ReadData=0, ReadValid=0; internal buffers cleared.
  - Reset asserted mid-beat drops MemRd immediately. A later MemAck is ignored.
- Size in bytes: S = 1, 2 or 4 for MemReadM 1, 2 or 3. off = AddrM[OFF_W-1:0].
- Split condition: split = (off + S > DATA_W/8).
- State machine: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - LoadReqM=1 with MemReadM!=0: latch AddrM, size, SignedM and split, then go to BEAT0.
  - LoadReqM=1 with MemReadM=0: ignored.
- BEAT0:
  - MemRd=1, MemAddr = latched address with the low OFF_W bits cleared.
  - Hold until MemAck=1, then capture MemData into lo_buf.
  - Next state is BEAT1 if split, otherwise DONE.
- BEAT1:
  - MemRd=1, MemAddr = BEAT0 address + DATA_W/8, wrapping modulo 2^ADDR_W.
  - On MemAck=1, capture MemData into hi_buf and go to DONE.
- DONE:
  - ReadValid=1 for exactly one cycle, with ReadData registered. Return to IDLE.
  - ReadData = ({hi_buf, lo_buf} >> (8*off)), low 8*S bits kept.
  - Upper bits are filled with bit 8*S-1 if SignedM=1, else 0.
  - hi_buf is treated as 0 when not split.
  - ReadData holds its value until the next DONE.
- MemRd is registered and is high only in BEAT0 and BEAT1.
- MemAck is ignored in IDLE and DONE and when MemRd=0.
- StallM (combinational):
  - High in BEAT0 and BEAT1.
  - High in IDLE during the cycle a valid LoadReqM is accepted.
  - Low in DONE and otherwise.
- LoadReqM is ignored while state is not IDLE; the pipeline is stalled in that case.
- Latency from accept to ReadValid, counting the DONE cycle:
  - Aligned load: 2 cycles plus memory wait cycles.
  - Split load: 3 cycles plus memory wait cycles.
- Back-to-back loads: a new request is accepted in the IDLE cycle after DONE.

Optional Feature:
MISALIGN_TRAP_EN. When defined:
- Adds output port MisalignExc (1 bit).
- A request is misaligned if a half load has off[0]!=0, or a word load has off[1:0]!=0.
- A misaligned request goes straight from IDLE to DONE with no memory beat.
- In DONE: MisalignExc=1 for one cycle with ReadValid=1 and ReadData unchanged.
- MisalignExc resets to 0.

When undefined:
- No MisalignExc port.
- All misaligned accesses are serviced, with split beats where needed.

Test Plan:
- Aligned word, AddrM=0x100, MemData=0xDEADBEEF, MemAck the cycle after MemRd rises -> one beat at MemAddr=0x100, ReadData=0xDEADBEEF, ReadValid 2 cycles after accept.
- Signed byte, AddrM=0x103, MemData=0x80FFFFFF -> ReadData=0xFFFFFF80. Unsigned byte at the same address -> 0x00000080.
- Split half (DATA_W=32), AddrM=0x203, beat0 MemData=0xAB000000, beat1 MemData=0x000000CD:
  - Beats at MemAddr 0x200 then 0x204.
  - Unsigned -> ReadData=0x0000CDAB; signed -> 0xFFFFCDAB.
  - StallM high for 3 cycles (accept, BEAT0, BEAT1).
- Wait states: MemAck delayed 3 cycles in BEAT0 -> MemRd and StallM held high throughout, MemAddr stable, ReadValid only after the ack.
- Reset mid-op: assert reset during a BEAT1 wait -> MemRd=0, StallM=0, ReadValid=0 immediately. A late MemAck after release produces no ReadValid.
- With MISALIGN_TRAP_EN defined, word load at AddrM=0x102 -> no MemRd, MisalignExc=1 and ReadValid=1 one cycle after accept. Without the macro, the same access produces two beats at 0x100 and 0x104.
